// File: rtl/lcd_pkt_pkg.sv
// Shared types, LCD command bytes and hex-to-ASCII helper for the packet display.
// Used by lcd_pkt_display and lcd_byte_writer.
package lcd_pkt_pkg;

    typedef enum logic [1:0] {
        S_POWER_WAIT,
        S_INIT,
        S_IDLE,
        S_REFRESH
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam int INIT_BYTES    = 4;
    localparam int REFRESH_BYTES = 34;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780-style bus: setup, E pulse, then post-E hold wait.
// A one-cycle done pulse is raised when the hold wait expires; RS/DATA stay put afterwards.
module lcd_byte_writer
    import lcd_pkt_pkg::*;
#(
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    input  logic       clear_in,
    output logic       done,
    output logic       lcd_enb,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} phase_e;

    phase_e      phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic        clear_q, clear_d;
    logic        enb_q, enb_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic [31:0] hold_lim;

    assign hold_lim = clear_q ? 32'(CLEAR_WAIT_CYC) : 32'(CMD_WAIT_CYC);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 32'd1;
        clear_d = clear_q;
        enb_d   = enb_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (phase_q)
            W_IDLE: begin
                cnt_d = 32'd0;
                if (start) begin
                    rs_d    = rs_in;
                    data_d  = data_in;
                    clear_d = clear_in;
                    phase_d = W_SETUP;
                end
            end
            W_SETUP: begin
                if (cnt_q + 32'd1 >= 32'(SETUP_CYC)) begin
                    enb_d   = 1'b1;
                    cnt_d   = 32'd0;
                    phase_d = W_PULSE;
                end
            end
            W_PULSE: begin
                if (cnt_q + 32'd1 >= 32'(E_PULSE_CYC)) begin
                    enb_d   = 1'b0;
                    cnt_d   = 32'd0;
                    phase_d = W_HOLD;
                end
            end
            W_HOLD: begin
                if (cnt_q + 32'd1 >= hold_lim) begin
                    done_d  = 1'b1;
                    cnt_d   = 32'd0;
                    phase_d = W_IDLE;
                end
            end
            default: phase_d = W_IDLE;
        endcase
    end

    // Reset drops E immediately, even mid-pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= W_IDLE;
            cnt_q   <= 32'd0;
            clear_q <= 1'b0;
            enb_q   <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            enb_q   <= enb_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign done     = done_q;
    assign lcd_enb  = enb_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_pkt_display.sv
// Shows src/dst/payload of an accepted update on a 2x16 character LCD.
// Define LCD_PKT_CNT_EN to add a 12-bit handshake counter on line 2, columns 12-15.
module lcd_pkt_display
    import lcd_pkt_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int PAY_W          = 8,
    parameter int POWER_WAIT_CYC = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [PAY_W-1:0]  payload_in,
    output logic              busy,
    output logic              lcd_enb,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_data
);

    localparam int AD = (ADDR_W + 3) / 4;
    localparam int PD = PAY_W / 4;
    localparam logic [31:0] SRC_TAG = "SRC:";
    localparam logic [39:0] DST_TAG = " DST:";
    localparam logic [31:0] PAY_TAG = "PAY:";

    lcd_state_e        state_q, state_d;
    logic [31:0]       pw_cnt_q, pw_cnt_d;
    logic [5:0]        idx_q, idx_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [PAY_W-1:0]  pay_q, pay_d;
`ifdef LCD_PKT_CNT_EN
    logic [11:0]       pkt_cnt_q, pkt_cnt_d;
`endif

    logic       wr_start;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_clear;
    logic       wr_done;
    logic [5:0] last_idx;

    function automatic logic [7:0] line1_char(input int col, input logic [7:0] s, input logic [7:0] d);
        logic [7:0] ch;
        ch = 8'h20;
        if (col < 4)
            ch = SRC_TAG[8*(3-col) +: 8];
        else if (col < 4 + AD)
            ch = hex_to_ascii(s[4*(AD-1-(col-4)) +: 4]);
        else if (col < 9 + AD)
            ch = DST_TAG[8*(4-(col-4-AD)) +: 8];
        else if (col < 9 + 2*AD)
            ch = hex_to_ascii(d[4*(AD-1-(col-9-AD)) +: 4]);
        return ch;
    endfunction

    function automatic logic [7:0] line2_char(input int col, input logic [31:0] p);
        logic [7:0] ch;
        ch = 8'h20;
        if (col < 4)
            ch = PAY_TAG[8*(3-col) +: 8];
        else if (col < 4 + PD)
            ch = hex_to_ascii(p[4*(PD-1-(col-4)) +: 4]);
        return ch;
    endfunction

    assign last_idx = (state_q == S_INIT) ? 6'(INIT_BYTES - 1) : 6'(REFRESH_BYTES - 1);

    always_comb begin
        state_d   = state_q;
        pw_cnt_d  = pw_cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        src_d     = src_q;
        dst_d     = dst_q;
        pay_d     = pay_q;
        wr_start  = 1'b0;
`ifdef LCD_PKT_CNT_EN
        pkt_cnt_d = pkt_cnt_q;
`endif
        unique case (state_q)
            S_POWER_WAIT: begin
                if (pw_cnt_q + 32'd1 >= 32'(POWER_WAIT_CYC)) begin
                    pw_cnt_d = 32'd0;
                    idx_d    = 6'd0;
                    state_d  = S_INIT;
                end else begin
                    pw_cnt_d = pw_cnt_q + 32'd1;
                end
            end
            // Issue one byte, then wait for its done pulse before advancing.
            S_INIT, S_REFRESH: begin
                if (pending_q) begin
                    if (wr_done) begin
                        pending_d = 1'b0;
                        if (idx_q == last_idx) begin
                            idx_d   = 6'd0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end else begin
                    wr_start  = 1'b1;
                    pending_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (upd_valid && ready_q) begin
                    src_d   = src_in;
                    dst_d   = dst_in;
                    pay_d   = payload_in;
                    idx_d   = 6'd0;
                    state_d = S_REFRESH;
`ifdef LCD_PKT_CNT_EN
                    pkt_cnt_d = pkt_cnt_q + 12'd1;
`endif
                end
            end
            default: state_d = S_POWER_WAIT;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // Byte selection: init command table, or the refresh line image.
    always_comb begin
        wr_rs   = 1'b0;
        wr_data = 8'h00;
        if (state_q == S_INIT) begin
            case (idx_q)
                6'd0:    wr_data = CMD_FUNC_SET;
                6'd1:    wr_data = CMD_DISP_ON;
                6'd2:    wr_data = CMD_ENTRY;
                default: wr_data = CMD_CLEAR;
            endcase
        end else if (idx_q == 6'd0) begin
            wr_data = CMD_LINE1;
        end else if (idx_q <= 6'd16) begin
            wr_rs   = 1'b1;
            wr_data = line1_char(int'(idx_q) - 1, 8'(src_q), 8'(dst_q));
        end else if (idx_q == 6'd17) begin
            wr_data = CMD_LINE2;
        end else begin
            wr_rs   = 1'b1;
            wr_data = line2_char(int'(idx_q) - 18, 32'(pay_q));
`ifdef LCD_PKT_CNT_EN
            if (idx_q == 6'd30)
                wr_data = 8'h23;
            else if (idx_q > 6'd30)
                wr_data = hex_to_ascii(pkt_cnt_q[4*(33-int'(idx_q)) +: 4]);
`endif
        end
        wr_clear = !wr_rs && (wr_data == CMD_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_POWER_WAIT;
            pw_cnt_q  <= 32'd0;
            idx_q     <= 6'd0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            src_q     <= '0;
            dst_q     <= '0;
            pay_q     <= '0;
`ifdef LCD_PKT_CNT_EN
            pkt_cnt_q <= 12'd0;
`endif
        end else begin
            state_q   <= state_d;
            pw_cnt_q  <= pw_cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            pay_q     <= pay_d;
`ifdef LCD_PKT_CNT_EN
            pkt_cnt_q <= pkt_cnt_d;
`endif
        end
    end

    lcd_byte_writer #(
        .SETUP_CYC      (SETUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wr_start),
        .rs_in    (wr_rs),
        .data_in  (wr_data),
        .clear_in (wr_clear),
        .done     (wr_done),
        .lcd_enb  (lcd_enb),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    assign upd_ready = ready_q;
    assign busy      = busy_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: doc/lcd_pkt_display.md
LCD_PKT_DISPLAY -- requirements
Module: lcd_pkt_display

Interface
REQ-001 Parameter ADDR_W, 4, width of src/dst address fields; legal 1..8.
REQ-002 Parameter PAY_W, 8, payload width; legal 4..32, multiple of 4.
REQ-003 Parameter POWER_WAIT_CYC, 750000, cycles waited after reset before the first command.
REQ-004 Parameter SETUP_CYC, 2, cycles RS/DATA are stable before E rises.
REQ-005 Parameter E_PULSE_CYC, 12, cycles E is held high.
REQ-006 Parameter CMD_WAIT_CYC, 2500, cycles after E falls before the next byte.
REQ-007 Parameter CLEAR_WAIT_CYC, 100000, post-E wait after command 0x01, replacing CMD_WAIT_CYC.
REQ-008 clk  input  1  system clock.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 upd_valid  input  1  update request.
REQ-011 upd_ready  output  1  block can accept an update.
REQ-012 src_in  input  ADDR_W  source address.
REQ-013 dst_in  input  ADDR_W  destination address.
REQ-014 payload_in  input  PAY_W  payload value.
REQ-015 busy  output  1  high during init or refresh.
REQ-016 lcd_enb  output  1  LCD enable strobe.
REQ-017 lcd_rs  output  1  0 = command, 1 = data.
REQ-018 lcd_rw  output  1  read/write; constant 0 (write-only).
REQ-019 lcd_data  output  8  LCD data bus.

Function
REQ-020 FSM states: POWER_WAIT, INIT, IDLE, REFRESH; POWER_WAIT->INIT when POWER_WAIT_CYC expires, INIT->IDLE after the last init byte, IDLE->REFRESH on handshake, REFRESH->IDLE after the last refresh byte.
REQ-021 Every byte is written as: drive RS/DATA; wait SETUP_CYC; E high for E_PULSE_CYC; E low with RS/DATA held for CMD_WAIT_CYC (CLEAR_WAIT_CYC after 0x01).
REQ-022 INIT sends commands 0x38, 0x0C, 0x06, 0x01 in that order.
REQ-023 upd_ready is high only in IDLE; a handshake occurs when upd_valid and upd_ready are both high on the same clk edge.
REQ-024 On handshake, src_in, dst_in and payload_in are captured into snapshot registers; later input changes do not alter the refresh in progress.
REQ-025 A refresh sends 34 bytes: 0x80, 16 line-1 characters, 0xC0, 16 line-2 characters.
REQ-026 Line 1: "SRC:" + ceil(ADDR_W/4) hex digits + " DST:" + ceil(ADDR_W/4) hex digits, space-padded to 16 characters.
REQ-027 Line 2: "PAY:" + PAY_W/4 hex digits, MSB first, space-padded to 16 characters.
REQ-028 Hex digit encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46, uppercase.
REQ-029 The display is rewritten only on handshake; IDLE drives no strobes.
REQ-030 upd_valid during POWER_WAIT, INIT or REFRESH is ignored; nothing is queued.
REQ-031 busy = 1 in every state except IDLE.

Reset
REQ-032 While rst_n is low: state=POWER_WAIT, counters=0, lcd_enb=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, upd_ready=0, busy=1, snapshots=0.
REQ-033 Reset asserted mid-byte or mid-refresh forces the REQ-032 values immediately, with no completion of the current E pulse, and restarts the full init sequence on release.

Configuration
REQ-034 Macro LCD_PKT_CNT_EN defined: a 12-bit handshake counter (reset 0, wraps 0xFFF->0x000, incremented on each handshake before the snapshot is displayed) is shown on line 2, columns 12-15, as "#" + 3 hex digits.
REQ-035 LCD_PKT_CNT_EN undefined: no counter register exists and columns 12-15 are spaces.

Structure
REQ-036 Package lcd_pkt_pkg holds the FSM state enum, LCD command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and the hex-to-ASCII function.
REQ-037 Sub-module lcd_byte_writer implements REQ-021 (start/done handshake, rs, data, clear flag); character selection stays in lcd_pkt_display.

Verification (bench uses POWER_WAIT_CYC=10, SETUP_CYC=2, E_PULSE_CYC=3, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=20)
REQ-038 Reset release -> 4 E pulses with rs=0 and data 0x38, 0x0C, 0x06, 0x01, then upd_ready=1 and busy=0.
REQ-039 src=0xA, dst=0xC, payload=0x05, upd_valid=1 for 1 cycle -> 34 pulses; line 1 "SRC:A DST:C" + 5 spaces, line 2 "PAY:05" + padding.
REQ-040 Change inputs to src=0x3, dst=0x4, payload=0xFF mid-refresh and pulse upd_valid -> displayed bytes unchanged; upd_ready stays 0 until 34 bytes complete.
REQ-041 rst_n low during byte 10 of a refresh -> lcd_enb=0 and lcd_data=0x00 at once; full init repeats after release.
REQ-042 With LCD_PKT_CNT_EN, 3 handshakes -> line 2 columns 12-15 show "#003"; preload counter to 0xFFF and send 1 handshake -> "#000".
REQ-043 ADDR_W=8, PAY_W=16, src=0x1F, dst=0xE0, payload=0xBEEF -> "SRC:1F DST:E0" + 3 spaces, "PAY:BEEF" + padding.
